// File: rtl/instant_buffer_ctrl.sv
// Sequencing controller for a windowed circular register buffer.
// Optional stall counter port enabled by INSTANT_BUFFER_CTRL_STATS_EN.
module instant_buffer_ctrl #(
  parameter int SIZE       = 8,
  parameter int WRITE_SIZE = 2,
  parameter int READ_SIZE  = 2,
  parameter int STRIDE     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(READ_SIZE+1)-1:0] out_cnt,
  output logic                           write_en,
  output logic [$clog2(SIZE)-1:0]        write_addr,
  output logic [$clog2(SIZE)-1:0]        read_addr,
  output logic [$clog2(SIZE+1)-1:0]      count,
  output logic                           busy,
  output logic                           done
`ifdef INSTANT_BUFFER_CTRL_STATS_EN
  ,
  output logic [15:0]                    stall_cycles
`endif
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE+1);
  localparam int OW = $clog2(READ_SIZE+1);

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] WR_C   = CW'(WRITE_SIZE);
  localparam logic [CW-1:0] RD_C   = CW'(READ_SIZE);
  localparam logic [CW-1:0] ST_C   = CW'(STRIDE);
  localparam logic [AW-1:0] WR_A   = AW'(WRITE_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          pop;
  logic [CW-1:0] rel;

`ifdef INSTANT_BUFFER_CTRL_STATS_EN
  logic [15:0]   stall_q, stall_d;
`endif

  // Handshake, window and status outputs from registered state.
  always_comb begin
    in_ready  = (state_q == RUN) &&
                ((SIZE_C - count_q) >= WR_C);
    write_en  = in_valid && in_ready && !flush;
    out_valid = ((state_q == RUN) && (count_q >= RD_C)) ||
                ((state_q == DRAIN) && (count_q != '0));
    pop       = out_valid && out_ready && !flush;
    rel       = '0;
    if (pop) begin
      rel = (count_q < ST_C) ? count_q : ST_C;
    end
    if (count_q < RD_C) begin
      out_cnt = OW'(count_q);
    end else begin
      out_cnt = OW'(READ_SIZE);
    end
    write_addr = waddr_q;
    read_addr  = raddr_q;
    count      = count_q;
    busy       = (state_q != IDLE);
    done       = done_q;
  end

  // Next state, pointers and occupancy; flush overrides everything.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (write_en) begin
      waddr_d = waddr_q + WR_A;
    end
    if (pop) begin
      raddr_d = raddr_q + rel[AW-1:0];
    end
    count_d = count_q + (write_en ? WR_C : '0) - rel;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (write_en && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (count_d == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          waddr_d = '0;
          raddr_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
      done_d  = 1'b0;
    end
  end

`ifdef INSTANT_BUFFER_CTRL_STATS_EN
  // Saturating count of producer stalls while running.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == RUN) && in_valid &&
                 !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    stall_cycles = stall_q;
  end
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef INSTANT_BUFFER_CTRL_STATS_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef INSTANT_BUFFER_CTRL_STATS_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_instant_buffer_ctrl.sv
// Directed vector bench for instant_buffer_ctrl
// (SIZE=8, WRITE_SIZE=2, READ_SIZE=2, STRIDE=1).
module tb_instant_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, flush, in_valid, in_last, out_ready;
  logic       in_ready, out_valid, write_en, busy, done;
  logic [1:0] out_cnt;
  logic [2:0] write_addr, read_addr;
  logic [3:0] count;
`ifdef INSTANT_BUFFER_CTRL_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instant_buffer_ctrl #(
    .SIZE(8), .WRITE_SIZE(2), .READ_SIZE(2), .STRIDE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_cnt(out_cnt),
    .write_en(write_en), .write_addr(write_addr),
    .read_addr(read_addr), .count(count),
    .busy(busy), .done(done)
`ifdef INSTANT_BUFFER_CTRL_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic st, fl, iv, il, ordy;
    logic busy, done, ir, ov, we;
    int   oc, cnt, wa, ra;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic st, fl, iv, il, ordy,
    input logic b, d, ir, ov, we,
    input int oc, cnt, wa, ra);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.il = il; v.ordy = ordy;
    v.busy = b; v.done = d; v.ir = ir; v.ov = ov; v.we = we;
    v.oc = oc; v.cnt = cnt; v.wa = wa; v.ra = ra;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, fl, iv, il, ordy);
    start = st; flush = fl; in_valid = iv;
    in_last = il; out_ready = ordy;
  endtask

  int  mem[8];
  int  mcnt, beats, wseq, rseq, cyc, wi;
  bit  running, exp_we, exp_ov, mpop;

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_count", count, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_raddr", read_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_start_ignored", busy, 0);

    // st fl iv il ordy | busy done ir ov we | oc cnt wa ra
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,1, 2,2,2,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,1, 2,4,4,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,1, 2,6,6,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0, 2,8,0,0));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,1,0, 2,8,0,0));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,1,0, 2,7,0,1));
    tbl.push_back(mk(0,0,1,0,1, 1,0,1,1,1, 2,6,0,2));
    tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0, 2,7,2,3));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,1,0, 2,7,2,3));
    tbl.push_back(mk(0,0,0,0,1, 1,0,1,1,0, 2,6,2,4));
    tbl.push_back(mk(0,0,0,0,1, 1,0,1,1,0, 2,5,2,5));
    tbl.push_back(mk(0,0,0,0,1, 1,0,1,1,0, 2,4,2,6));
    tbl.push_back(mk(0,0,0,0,1, 1,0,1,1,0, 2,3,2,7));
    tbl.push_back(mk(0,0,0,0,1, 1,0,1,1,0, 2,2,2,0));
    tbl.push_back(mk(0,0,1,1,1, 1,0,1,0,1, 1,1,2,1));
    tbl.push_back(mk(0,0,1,0,1, 1,0,0,1,0, 2,3,4,1));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,1,0, 2,2,4,2));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,1,0, 1,1,4,3));
    tbl.push_back(mk(0,0,0,0,1, 0,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,1, 2,2,2,0));
    tbl.push_back(mk(0,0,1,0,1, 1,0,1,1,1, 2,4,4,0));
    tbl.push_back(mk(1,1,1,0,1, 1,0,1,1,0, 2,5,6,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,0,1, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1, 1,0,1,1,0, 2,2,2,0));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].il, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("r%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("r%0d_done", i), done, tbl[i].done);
      chk($sformatf("r%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("r%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("r%0d_write_en", i), write_en, tbl[i].we);
      chk($sformatf("r%0d_out_cnt", i), out_cnt, tbl[i].oc);
      chk($sformatf("r%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("r%0d_waddr", i), write_addr, tbl[i].wa);
      chk($sformatf("r%0d_raddr", i), read_addr, tbl[i].ra);
    end

    // streaming frame with a data scoreboard across pointer wrap
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    mcnt = 0; beats = 0; wseq = 0; rseq = 0; cyc = 0;
    running = 1'b1;
    while ((running || mcnt != 0) && cyc < 400) begin
      #1;
      drive(1'b0, 1'b0, beats < 20, beats == 19,
            running ? cyc[0] : 1'b1);
      @(negedge clk);
      exp_we = running && in_valid && (8 - mcnt >= 2);
      exp_ov = running ? (mcnt >= 2) : (mcnt > 0);
      mpop   = exp_ov && out_ready;
      chk("stream_write_en", write_en, exp_we);
      chk("stream_out_valid", out_valid, exp_ov);
      chk("stream_count", count, mcnt);
      chk("stream_done_early", done, 0);
      if (mpop) begin
        chk("stream_data", mem[read_addr], rseq);
        rseq++;
      end
      if (exp_we) begin
        wi = (int'(write_addr) + 1) % 8;
        mem[write_addr] = wseq;
        mem[wi] = wseq + 1;
        wseq += 2;
        beats++;
        if (in_last) running = 1'b0;
      end
      mcnt = mcnt + (exp_we ? 2 : 0) - (mpop ? 1 : 0);
      @(posedge clk);
      cyc++;
    end
    chk("stream_no_timeout", cyc < 400, 1);
    chk("stream_words_read", rseq, 40);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_done_pulse", done, 1);
    chk("stream_busy_fall", busy, 0);
    chk("stream_idle_count", count, 0);
    @(posedge clk);
    @(negedge clk);
    chk("stream_done_once", done, 0);
    chk("stream_stay_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instant_buffer_ctrl.md
Name: instant_buffer_ctrl

Overview:
Sequencing controller for the windowed circular register buffer: it generates write_addr, read_addr and write_en for that buffer. It exposes a valid/ready handshake to a producer that delivers WRITE_SIZE words per beat and to a consumer that reads a READ_SIZE window and releases STRIDE words per beat. It tracks occupancy, frames each transfer with start/last, and drains the tail of a frame.

Parameters:
SIZE, 8, buffer depth in words; must be a power of 2.
WRITE_SIZE, 2, words written per accepted producer beat; must be ≤ SIZE.
READ_SIZE, 2, words in the consumer read window; must be ≤ SIZE.
STRIDE, 1, words released per accepted consumer beat; must satisfy 1 ≤ STRIDE ≤ READ_SIZE.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-low: rst=0 at a rising edge resets the block.
start  in  1  begins a frame; only honoured in IDLE.
flush  in  1  aborts the current frame.
in_valid  in  1  producer has WRITE_SIZE words on the buffer inputs.
in_last  in  1  qualifies the final producer beat of the frame.
in_ready  out  1  controller accepts a producer beat.
out_valid  out  1  read window holds consumable data.
out_ready  in  1  consumer releases words this cycle.
out_cnt  out  $clog2(READ_SIZE+1)  number of valid words in the window, equal to min(count, READ_SIZE).
write_en  out  1  buffer write strobe.
write_addr  out  $clog2(SIZE)  buffer write base address.
read_addr  out  $clog2(SIZE)  buffer read base address.
count  out  $clog2(SIZE+1)  occupancy in words.
busy  out  1  high when state ≠ IDLE.
done  out  1  one-cycle pulse at normal frame completion.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - write_addr=0, read_addr=0, count=0.
  - done=0, busy=0, in_ready=0, out_valid=0, write_en=0, out_cnt=0.
- States and transitions:
  - IDLE: start=1 → RUN. Pointers and count are already 0 in IDLE.
  - RUN: an accepted beat with in_last=1 → DRAIN.
  - DRAIN: when count reaches 0 after a pop → IDLE, with done=1 in the following cycle.
- flush:
  - In RUN or DRAIN: next state IDLE; pointers and count cleared to 0; done is not pulsed.
  - flush has priority over start, writes and pops in the same cycle.
  - flush in IDLE has no effect.
- Combinational outputs, all from registered state:
  - in_ready = (state==RUN) && (SIZE−count ≥ WRITE_SIZE).
  - write_en = in_valid && in_ready && !flush.
  - out_valid = (state==RUN && count ≥ READ_SIZE) || (state==DRAIN && count > 0).
- Pop: pop = out_valid && out_ready && !flush. Words released per pop = min(STRIDE, count).
- Register updates at each edge:
  - count ← count + (write_en ? WRITE_SIZE : 0) − released words. A simultaneous write and pop are both applied.
  - write_addr ← write_addr + WRITE_SIZE on write, modulo SIZE (natural wrap of the address width).
  - read_addr ← read_addr + released words on pop, modulo SIZE.
- Latency: a word written at edge N is readable at read_addr in cycle N+1. Because out_valid is derived from registered count, it never exposes unwritten data.
- count never exceeds SIZE (guaranteed by in_ready) and never underflows (guaranteed by min()).
- In DRAIN, out_cnt < READ_SIZE marks a partial window; words beyond out_cnt are don't-care.
- start while busy: ignored.
- in_valid in IDLE or DRAIN: not accepted.
- done is registered and lasts exactly one cycle; busy falls in the same cycle that done rises.

Optional Feature:
INSTANT_BUFFER_CTRL_STATS_EN:
- Defined: adds output stall_cycles [15:0].
  - Increments each cycle with state==RUN && in_valid && !in_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.
  - Holds its value in IDLE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
(SIZE=8, WRITE_SIZE=2, READ_SIZE=2, STRIDE=1)
1. Reset: hold rst=0 for 2 cycles with random inputs → all outputs 0, busy=0; start during reset is ignored.
2. Fill: start, then 4 producer beats with out_ready=0 → write_addr sequence 0,2,4,6→0; count 2,4,6,8; out_valid=1 from count=2; in_ready=0 at count=8.
3. Concurrent write and pop at count=6 → count=7, write_addr+=2, read_addr+=1. At count=7, in_ready=0 (free=1).
4. Wrap: stream 20 beats with out_ready alternating → read_addr wraps 7→0; a scoreboard confirms that window data equals the written sequence in order.
5. Drain: in_last on a beat reaching count=3, then out_ready=1 → out_cnt 2,2,1; count 2,1,0; done pulses once; busy falls; state IDLE.
6. Flush: at count=5 in RUN, assert flush and start together → next cycle count=0, pointers=0, IDLE, no done; a subsequent start begins a clean frame.
